// File: rtl/collector_pkg.sv
// Types shared by the sample capture front-end and the SDRAM controller.
package collector_pkg;

    localparam int SDRAM_ADDR_WIDTH = 25;

    typedef logic [SDRAM_ADDR_WIDTH-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        WRITE   = 2'd2,
        DRAIN   = 2'd3
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and a registered head word.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_next;
    logic [AW:0]      count;
    logic [AW:0]      count_next;
    logic             do_push;
    logic             do_pop;

    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;
    assign rd_next = rd_ptr + 1'b1;

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            o_full  <= 1'b0;
            o_empty <= 1'b1;
            o_head  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_next;
            end
            count   <= count_next;
            o_full  <= (count_next == (AW+1)'(DEPTH));
            o_empty <= (count_next == '0);
            // The slot becoming head may be the one written this very cycle.
            if (do_pop) begin
                if (count == (AW+1)'(1) && do_push) begin
                    o_head <= i_data;
                end else if (count > (AW+1)'(1)) begin
                    o_head <= mem[rd_next];
                end
            end else if (do_push && o_empty) begin
                o_head <= i_data;
            end
        end
    end

endmodule

// File: rtl/sample_collector.sv
// Sample capture front-end: buffers an 8-bit stream and writes it byte by byte
// into a ring region of SDRAM through a level request / pulse acknowledge interface.
module sample_collector
    import collector_pkg::*;
#(
    parameter int     ADDR_WIDTH = SDRAM_ADDR_WIDTH,
    parameter int     FIFO_DEPTH = 16,
    parameter longint BASE_ADDR  = 0,
    parameter longint RING_LEN   = 64'd1 << 25
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic                  i_valid,
    input  logic [7:0]            i_data,
    output logic                  o_ready,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [7:0]            o_D,
    output logic                  o_we,
    input  logic                  i_mem_done,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH-1:0] o_count,
    output logic                  o_overflow,
    output logic                  o_wrapped
);
    // state    | meaning
    // IDLE     | waiting for i_start; count and flags hold their last values
    // CAPTURE  | accepting samples; launches a write when the FIFO has data
    // WRITE    | write request outstanding; still accepting samples
    // DRAIN    | stopped; writing out whatever is left in the FIFO

    localparam logic [ADDR_WIDTH-1:0] RING_FIRST = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] RING_LAST  = ADDR_WIDTH'(BASE_ADDR + RING_LEN - 1);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   wr_ptr;
    logic [ADDR_WIDTH-1:0]   ptr_next;
    logic                    ptr_wrap;
    logic                    stop_pend;
    logic                    accepting;
    logic                    push;
    logic                    pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [7:0]              fifo_head;

    assign accepting = (state == CAPTURE) || (state == WRITE);
    // A stop seen during WRITE closes the input immediately, not after the write.
    assign o_ready   = !fifo_full && ((state == CAPTURE) || (state == WRITE && !stop_pend));
    assign push      = i_valid && o_ready;
    assign pop       = o_we && i_mem_done;
    assign ptr_wrap  = (wr_ptr == RING_LAST);
    assign ptr_next  = ptr_wrap ? RING_FIRST : wr_ptr + 1'b1;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_data  (i_data),
        .i_pop   (pop),
        .o_head  (fifo_head),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= IDLE;
            wr_ptr     <= RING_FIRST;
            stop_pend  <= 1'b0;
            o_addr     <= '0;
            o_D        <= '0;
            o_we       <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_count    <= '0;
            o_overflow <= 1'b0;
            o_wrapped  <= 1'b0;
        end else begin
            o_done <= 1'b0;

            if (accepting && i_valid && fifo_full) begin
                o_overflow <= 1'b1;
            end

            if (pop) begin
                o_we   <= 1'b0;
                wr_ptr <= ptr_next;
                if (ptr_wrap) begin
                    o_wrapped <= 1'b1;
                end
                if (!(&o_count)) begin
                    o_count <= o_count + 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (i_start) begin
                        o_count    <= '0;
                        o_overflow <= 1'b0;
                        o_wrapped  <= 1'b0;
                        wr_ptr     <= RING_FIRST;
                        stop_pend  <= 1'b0;
                        o_busy     <= 1'b1;
                        state      <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (i_stop) begin
                        state <= DRAIN;
                    end else if (!fifo_empty && !o_we) begin
                        o_D    <= fifo_head;
                        o_addr <= wr_ptr;
                        o_we   <= 1'b1;
                        state  <= WRITE;
                    end
                end
                WRITE: begin
                    if (i_stop) begin
                        stop_pend <= 1'b1;
                    end
                    if (pop) begin
                        stop_pend <= 1'b0;
                        state     <= (stop_pend || i_stop) ? DRAIN : CAPTURE;
                    end
                end
                DRAIN: begin
                    if (!o_we) begin
                        if (!fifo_empty) begin
                            o_D    <= fifo_head;
                            o_addr <= wr_ptr;
                            o_we   <= 1'b1;
                        end else begin
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sample_collector.sv
// Scoreboard bench for sample_collector: a default-ring instance and a small
// 4-byte ring at 0x100 run in lockstep from the same stimulus.
module tb_sample_collector;
    import collector_pkg::*;

    logic        i_clk      = 1'b0;
    logic        i_rst      = 1'b0;
    logic        i_start    = 1'b0;
    logic        i_stop     = 1'b0;
    logic        i_valid    = 1'b0;
    logic [7:0]  i_data     = 8'h00;
    logic        i_mem_done = 1'b0;

    logic        o_ready, o_we, o_busy, o_done, o_overflow, o_wrapped;
    addr_t       o_addr, o_count;
    logic [7:0]  o_D;

    logic        r_ready, r_we, r_busy, r_done, r_overflow, r_wrapped;
    addr_t       r_addr, r_count;
    logic [7:0]  r_D;

    int          n_checks = 0;
    int          n_fail   = 0;

    logic [7:0]  sb_q [$];
    logic [7:0]  exp_d;
    int          exp_k      = 0;
    int          n_accept   = 0;
    int          done_cnt   = 0;
    int          resp_delay = 0;
    bit          resp_en    = 1'b1;
    bit          spurious   = 1'b0;
    int          wait_cnt   = 0;
    logic        prev_we    = 1'b0;
    addr_t       prev_addr;
    logic [7:0]  prev_D;

    sample_collector dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_stop     (i_stop),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .o_ready    (o_ready),
        .o_addr     (o_addr),
        .o_D        (o_D),
        .o_we       (o_we),
        .i_mem_done (i_mem_done),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_count    (o_count),
        .o_overflow (o_overflow),
        .o_wrapped  (o_wrapped)
    );

    sample_collector #(
        .BASE_ADDR (64'h100),
        .RING_LEN  (64'd4)
    ) dut_ring (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_stop     (i_stop),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .o_ready    (r_ready),
        .o_addr     (r_addr),
        .o_D        (r_D),
        .o_we       (r_we),
        .i_mem_done (i_mem_done),
        .o_busy     (r_busy),
        .o_done     (r_done),
        .o_count    (r_count),
        .o_overflow (r_overflow),
        .o_wrapped  (r_wrapped)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Accept monitor, write responder and commit scoreboard, all at the falling edge.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            i_mem_done = 1'b0;
            wait_cnt   = 0;
            prev_we    = 1'b0;
        end else begin
            if (i_valid && o_ready) begin
                sb_q.push_back(i_data);
                n_accept++;
            end
            if (o_done) begin
                done_cnt++;
                chk("busy_at_done", 64'(o_busy), 64'd0);
            end
            if (prev_we && o_we) begin
                chk("addr_stable", 64'(o_addr), 64'(prev_addr));
                chk("data_stable", 64'(o_D), 64'(prev_D));
            end
            if (i_mem_done) begin
                i_mem_done = 1'b0;
                if (prev_we) begin
                    chk("we_drop", 64'(o_we), 64'd0);
                end
            end else if (o_we && resp_en) begin
                if (wait_cnt >= resp_delay) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_write", 64'(o_we), 64'd0);
                    end else begin
                        exp_d = sb_q.pop_front();
                        chk("wr_data", 64'(o_D), 64'(exp_d));
                        chk("wr_addr", 64'(o_addr), 64'(exp_k));
                        chk("ring_addr", 64'(r_addr), 64'(32'h100 + (exp_k % 4)));
                        chk("ring_data", 64'(r_D), 64'(exp_d));
                        chk("ring_wrapped", 64'(r_wrapped), 64'(exp_k >= 4));
                        chk("count_before_commit", 64'(o_count), 64'(exp_k));
                        exp_k++;
                    end
                    i_mem_done = 1'b1;
                    wait_cnt   = 0;
                end else begin
                    wait_cnt++;
                end
            end else if (spurious && !o_we) begin
                i_mem_done = 1'b1;
                spurious   = 1'b0;
            end
            prev_we   = o_we;
            prev_addr = o_addr;
            prev_D    = o_D;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pulse_start(input bit expect_accept);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        if (expect_accept) begin
            exp_k = 0;
        end
    endtask

    task automatic pulse_stop();
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d);
        int t = 0;
        i_valid = 1'b1;
        i_data  = d;
        @(negedge i_clk);
        while (!o_ready && t < 200) begin
            @(negedge i_clk);
            t++;
        end
        if (!o_ready) begin
            chk("send_timeout", 64'(t), 64'd0);
        end
        tick();
        i_valid = 1'b0;
    endtask

    task automatic wait_drained();
        int t = 0;
        while ((sb_q.size() != 0 || o_we) && t < 400) begin
            tick();
            t++;
        end
        if (sb_q.size() != 0 || o_we) begin
            chk("drain_timeout", 64'(sb_q.size()), 64'd0);
        end
    endtask

    task automatic wait_done();
        int d0 = done_cnt;
        int t  = 0;
        while (done_cnt == d0 && t < 400) begin
            tick();
            t++;
        end
        repeat (3) tick();
        chk("done_pulses", 64'(done_cnt - d0), 64'd1);
        chk("busy_after_done", 64'(o_busy), 64'd0);
        chk("ready_after_done", 64'(o_ready), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;

        repeat (3) tick();
        chk("rst_ready", 64'(o_ready), 64'd0);
        chk("rst_we", 64'(o_we), 64'd0);
        chk("rst_addr", 64'(o_addr), 64'd0);
        chk("rst_data", 64'(o_D), 64'd0);
        chk("rst_busy", 64'(o_busy), 64'd0);
        chk("rst_done", 64'(o_done), 64'd0);
        chk("rst_count", 64'(o_count), 64'd0);
        chk("rst_overflow", 64'(o_overflow), 64'd0);
        chk("rst_wrapped", 64'(o_wrapped), 64'd0);
        i_rst = 1'b1;
        tick();

        // Basic capture of 0x11..0x14 with a one-cycle acknowledge.
        pulse_start(1'b1);
        chk("busy_after_start", 64'(o_busy), 64'd1);
        chk("ready_in_capture", 64'(o_ready), 64'd1);
        i_valid = 1'b1;
        i_data  = 8'h11;
        tick();
        i_valid = 1'b0;
        chk("latency_we_edge_n", 64'(o_we), 64'd0);
        tick();
        chk("latency_we_edge_n1", 64'(o_we), 64'd1);
        for (int i = 2; i <= 4; i++) send_byte(8'(8'h10 + i));
        wait_drained();
        chk("basic_count", 64'(o_count), 64'd4);
        chk("basic_overflow", 64'(o_overflow), 64'd0);
        chk("basic_wrapped", 64'(o_wrapped), 64'd0);
        chk("ring4_wrapped", 64'(r_wrapped), 64'd1);
        pulse_stop();
        wait_done();

        // Small ring wraps after its fourth commit; a new start clears the flag.
        pulse_start(1'b1);
        chk("start_clears_wrapped", 64'(r_wrapped), 64'd0);
        for (int i = 0; i < 6; i++) send_byte(8'(8'h20 + i));
        wait_drained();
        chk("ring_count", 64'(r_count), 64'd6);
        chk("ring_wrapped_end", 64'(r_wrapped), 64'd1);
        pulse_stop();
        wait_done();

        // Acknowledge withheld for 40 cycles with valid held high.
        pulse_start(1'b1);
        resp_en = 1'b0;
        a0 = n_accept;
        i_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            i_data = 8'(8'h40 + i);
            tick();
        end
        i_valid = 1'b0;
        chk("ovf_accepted", 64'(n_accept - a0), 64'd16);
        chk("ovf_ready", 64'(o_ready), 64'd0);
        chk("ovf_flag", 64'(o_overflow), 64'd1);
        chk("ovf_we_held", 64'(o_we), 64'd1);
        resp_en = 1'b1;
        wait_drained();
        chk("ovf_count", 64'(o_count), 64'd16);
        pulse_stop();
        wait_done();
        chk("ovf_sticky", 64'(o_overflow), 64'd1);

        // Stop while a write is outstanding with more samples buffered.
        pulse_start(1'b1);
        chk("start_clears_overflow", 64'(o_overflow), 64'd0);
        resp_en = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(8'(8'h70 + i));
        chk("stop_in_write_we", 64'(o_we), 64'd1);
        pulse_stop();
        chk("ready_after_stop", 64'(o_ready), 64'd0);
        i_valid = 1'b1;
        i_data  = 8'h99;
        tick();
        i_valid = 1'b0;
        resp_en = 1'b1;
        wait_done();
        chk("stop_count", 64'(o_count), 64'd5);

        // Reset while a write is outstanding.
        pulse_start(1'b1);
        resp_en = 1'b0;
        for (int i = 0; i < 3; i++) send_byte(8'(8'hA0 + i));
        chk("pre_reset_we", 64'(o_we), 64'd1);
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        chk("mid_rst_we", 64'(o_we), 64'd0);
        chk("mid_rst_addr", 64'(o_addr), 64'd0);
        chk("mid_rst_data", 64'(o_D), 64'd0);
        chk("mid_rst_busy", 64'(o_busy), 64'd0);
        chk("mid_rst_count", 64'(o_count), 64'd0);
        chk("mid_rst_ready", 64'(o_ready), 64'd0);
        chk("mid_rst_overflow", 64'(o_overflow), 64'd0);
        chk("mid_rst_wrapped", 64'(o_wrapped), 64'd0);
        sb_q.delete();
        exp_k = 0;
        tick();
        tick();
        i_rst = 1'b1;
        tick();
        resp_en = 1'b1;
        pulse_start(1'b1);
        send_byte(8'h55);
        send_byte(8'h56);
        wait_drained();
        chk("post_rst_count", 64'(o_count), 64'd2);
        pulse_stop();
        wait_done();

        // Stop and acknowledge in IDLE, start while busy.
        pulse_stop();
        tick();
        chk("idle_stop_busy", 64'(o_busy), 64'd0);
        chk("idle_stop_count", 64'(o_count), 64'd2);
        spurious = 1'b1;
        repeat (3) tick();
        chk("spurious_ack_count", 64'(o_count), 64'd2);
        chk("spurious_ack_we", 64'(o_we), 64'd0);
        pulse_start(1'b1);
        send_byte(8'h60);
        send_byte(8'h61);
        wait_drained();
        pulse_start(1'b0);
        chk("busy_start_count", 64'(o_count), 64'd2);
        chk("busy_start_busy", 64'(o_busy), 64'd1);
        send_byte(8'h62);
        wait_drained();
        chk("busy_start_count_end", 64'(o_count), 64'd3);
        pulse_stop();
        wait_done();

        chk("ring_final_ready", 64'(r_ready), 64'd0);
        chk("ring_final_we", 64'(r_we), 64'd0);
        chk("ring_final_busy", 64'(r_busy), 64'd0);
        chk("ring_final_done", 64'(r_done), 64'd0);
        chk("ring_final_overflow", 64'(r_overflow), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
